// File: rtl/toggle_if.sv
// Bundle of the toggle-link signals: the source drives tog/clr and the decoder
// returns the filtered level, the event pulses and the counter status.
interface toggle_if #(
    parameter int CNT_W = 8
);
    logic             tog;
    logic             clr;
    logic             q_dec;
    logic             evt;
    logic             rise;
    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] rate;
    logic             rate_vld;
    logic             ovf;

    modport master (
        output tog, clr,
        input  q_dec, evt, rise, evt_cnt, rate, rate_vld, ovf
    );

    modport slave (
        input  tog, clr,
        output q_dec, evt, rise, evt_cnt, rate, rate_vld, ovf
    );
endinterface

// File: rtl/toggle_decoder.sv
// Recovers discrete events from a toggle-encoded level: deglitch filter,
// one-cycle event/rise pulses, running event count and per-window event rate.
module toggle_decoder #(
    parameter int FILT_LEN = 2,
    parameter int CNT_W    = 8,
    parameter int WIN_LEN  = 100,
    parameter int SAT      = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    toggle_if.slave  bus
);

    localparam logic [0:0]       STABLE    = 1'b0;
    localparam logic [0:0]       CAND      = 1'b1;
    localparam logic [3:0]       FILT_LAST = 4'(FILT_LEN - 1);
    localparam logic [15:0]      WIN_LAST  = 16'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [0:0]       state;
    logic [3:0]       fcnt;
    logic             q_dec;
    logic             evt;
    logic             rise;
    logic [CNT_W-1:0] evt_cnt;
    logic             ovf;
    logic [15:0]      wcnt;
    logic [CNT_W-1:0] win_acc;
    logic [CNT_W-1:0] rate;
    logic             rate_vld;

    logic differ;
    logic accept;
    logic boundary;

    // Saturating increment: once at all-ones the value sticks.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (v == CNT_MAX || !inc)
            return v;
        return v + CNT_ONE;
    endfunction

    assign differ   = (bus.tog != q_dec);
    assign accept   = differ && (((state == STABLE) && (FILT_LEN == 1)) ||
                                 ((state == CAND) && (fcnt == FILT_LAST)));
    assign boundary = (wcnt == WIN_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= STABLE;
            fcnt  <= 4'd0;
            q_dec <= 1'b0;
            evt   <= 1'b0;
            rise  <= 1'b0;
        end else begin
            evt  <= accept;
            rise <= accept & ~q_dec;
            if (accept) begin
                q_dec <= ~q_dec;
                state <= STABLE;
                fcnt  <= 4'd0;
            end else if (state == STABLE) begin
                if (differ) begin
                    state <= CAND;
                    fcnt  <= 4'd1;
                end
            end else if (!differ) begin
                // level fell back before the filter length: a glitch, drop it
                state <= STABLE;
                fcnt  <= 4'd0;
            end else begin
                fcnt <= fcnt + 4'd1;
            end
        end
    end

    // clr touches only the counters and the window; the filter keeps running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_cnt  <= '0;
            ovf      <= 1'b0;
            wcnt     <= 16'd0;
            win_acc  <= '0;
            rate     <= '0;
            rate_vld <= 1'b0;
        end else if (bus.clr) begin
            evt_cnt  <= '0;
            ovf      <= 1'b0;
            wcnt     <= 16'd0;
            win_acc  <= '0;
            rate_vld <= 1'b0;
        end else begin
            if (accept) begin
                if (evt_cnt == CNT_MAX) begin
                    ovf <= 1'b1;
                    if (SAT == 0)
                        evt_cnt <= '0;
                end else begin
                    evt_cnt <= evt_cnt + CNT_ONE;
                end
            end
            if (boundary) begin
                rate     <= sat_inc(win_acc, accept);
                win_acc  <= '0;
                wcnt     <= 16'd0;
                rate_vld <= 1'b1;
            end else begin
                win_acc  <= sat_inc(win_acc, accept);
                wcnt     <= wcnt + 16'd1;
                rate_vld <= 1'b0;
            end
        end
    end

    assign bus.q_dec    = q_dec;
    assign bus.evt      = evt;
    assign bus.rise     = rise;
    assign bus.evt_cnt  = evt_cnt;
    assign bus.ovf      = ovf;
    assign bus.rate     = rate;
    assign bus.rate_vld = rate_vld;

endmodule
